// File: rtl/alu_mul_seq.sv
// Iterative unsigned 32x32->64 shift-add multiplier.
// It has no adder of its own and uses the shared datapath ALU for each add and each carry test.
module alu_mul_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] mcand,
  input  logic [31:0] mplier,
  output logic        ready,
  output logic        done,
  output logic [31:0] product_hi,
  output logic [31:0] product_lo,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out,
  input  logic        alu_zero
);

  // state | meaning
  // IDLE  | ready; hi/lo hold the last product
  // TEST  | inspect lo[0], the current multiplier bit
  // ADD   | ALU computes hi+mc into sum
  // CARRY | ALU compares sum<mc to recover the add carry; shift {carry,sum,lo}
  // SHIFT | multiplier bit was 0; shift {0,hi,lo}
  // DONE  | one-cycle done pulse

  localparam int         WIDTH   = 32;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_IDLE = 4'b0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TEST  = 3'd1,
    ADD   = 3'd2,
    CARRY = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] hi, lo, mc, sum;
  logic [4:0]       cnt;
  logic             carry;
  logic             last_bit;

  // The ALU flags sum<mc as a nonzero result, so a wrap shows up as Zero=0.
  assign carry    = ~alu_zero;
  assign last_bit = (cnt == 5'd31);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    done     = 1'b0;
    alu_op   = OP_IDLE;
    alu_a    = '0;
    alu_b    = '0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nx = TEST;
      end
      TEST: begin
        state_nx = lo[0] ? ADD : SHIFT;
      end
      ADD: begin
        alu_op   = OP_ADD;
        alu_a    = hi;
        alu_b    = mc;
        state_nx = CARRY;
      end
      CARRY: begin
        alu_op   = OP_SLT;
        alu_a    = sum;
        alu_b    = mc;
        state_nx = last_bit ? DONE : TEST;
      end
      SHIFT: begin
        state_nx = last_bit ? DONE : TEST;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi  <= '0;
      lo  <= '0;
      mc  <= '0;
      sum <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mc  <= mcand;
            lo  <= mplier;
            hi  <= '0;
            cnt <= '0;
          end
        end
        ADD: begin
          sum <= alu_out;
        end
        CARRY: begin
          hi <= {carry, sum[WIDTH-1:1]};
          lo <= {sum[0], lo[WIDTH-1:1]};
          if (!last_bit) cnt <= cnt + 5'd1;
        end
        SHIFT: begin
          hi <= {1'b0, hi[WIDTH-1:1]};
          lo <= {hi[0], lo[WIDTH-1:1]};
          if (!last_bit) cnt <= cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign product_hi = hi;
  assign product_lo = lo;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural model of the shared ALU.
module tb_alu_mul_seq;

  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_IDLE = 4'b0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] mcand = '0;
  logic [31:0] mplier = '0;
  logic        ready, done;
  logic [31:0] product_hi, product_lo;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic [31:0] alu_out;
  logic        alu_zero;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Shared ALU model: add, unsigned set-less-than, zero otherwise.
  always_comb begin
    alu_out = '0;
    if (alu_op == OP_ADD)      alu_out = alu_a + alu_b;
    else if (alu_op == OP_SLT) alu_out = {31'd0, (alu_a < alu_b)};
    alu_zero = (alu_out == 32'd0);
  end

  alu_mul_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mcand(mcand), .mplier(mplier),
    .ready(ready), .done(done), .product_hi(product_hi), .product_lo(product_lo),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .alu_zero(alu_zero)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Starts one operation from IDLE and observes it; lat=-1 if done never arrives.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, output int lat,
                        output logic [31:0] ph, output logic [31:0] pl, output int nadd,
                        output int nslt, output int ncarry, output int last_alu);
    lat = -1; ph = '0; pl = '0; nadd = 0; nslt = 0; ncarry = 0; last_alu = 0;
    start = 1'b1; mcand = a; mplier = b;
    for (int c = 1; c <= 200; c++) begin
      step();
      start = 1'b0;
      if (alu_op == OP_ADD) nadd++;
      if (alu_op == OP_SLT) begin
        nslt++;
        if (!alu_zero) ncarry++;
      end
      if (alu_op != OP_IDLE) last_alu = c;
      if (done) begin
        lat = c; ph = product_hi; pl = product_lo;
        break;
      end
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({ready, done} !== 2'b10) begin
      n_err++; $display("FAIL reset_flags: got ready,done=%b required 10", {ready, done});
    end
    n_cmp++;
    if ({product_hi, product_lo} !== 64'd0) begin
      n_err++; $display("FAIL reset_product: got %h required 0", {product_hi, product_lo});
    end
    n_cmp++;
    if ({alu_op, alu_a, alu_b} !== 68'd0) begin
      n_err++; $display("FAIL reset_alu: got op=%h a=%h b=%h required all 0", alu_op, alu_a, alu_b);
    end
  endtask

  task automatic test_small();
    int lat, na, ns, nc, la;
    logic [31:0] ph, pl;
    do_mul(32'd5, 32'd3, lat, ph, pl, na, ns, nc, la);
    n_cmp++;
    if (lat !== 67) begin n_err++; $display("FAIL small_latency: got %0d required 67", lat); end
    n_cmp++;
    if ({ph, pl} !== 64'd15) begin n_err++; $display("FAIL small_product: got %h required 15", {ph, pl}); end
    n_cmp++;
    if (na !== 2 || ns !== 2 || la !== 6) begin
      n_err++; $display("FAIL small_alu_use: got add=%0d slt=%0d last=%0d required 2 2 6", na, ns, la);
    end
    step();
    step();
    n_cmp++;
    if (ready !== 1'b1 || done !== 1'b0 || {product_hi, product_lo} !== 64'd15) begin
      n_err++; $display("FAIL small_hold: got ready=%b done=%b prod=%h required 1 0 15",
                        ready, done, {product_hi, product_lo});
    end
  endtask

  task automatic test_max();
    int lat, na, ns, nc, la;
    logic [31:0] ph, pl;
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, ph, pl, na, ns, nc, la);
    n_cmp++;
    if (lat !== 97) begin n_err++; $display("FAIL max_latency: got %0d required 97", lat); end
    n_cmp++;
    if ({ph, pl} !== 64'hFFFF_FFFE_0000_0001) begin
      n_err++; $display("FAIL max_product: got %h required fffffffe00000001", {ph, pl});
    end
    n_cmp++;
    if (nc !== 31) begin n_err++; $display("FAIL max_carries: got %0d required 31", nc); end
    step();
  endtask

  task automatic test_high_bit();
    int lat, na, ns, nc, la;
    logic [31:0] ph, pl;
    do_mul(32'h8000_0000, 32'd3, lat, ph, pl, na, ns, nc, la);
    n_cmp++;
    if (lat !== 67) begin n_err++; $display("FAIL hibit_latency: got %0d required 67", lat); end
    n_cmp++;
    if ({ph, pl} !== 64'h0000_0001_8000_0000) begin
      n_err++; $display("FAIL hibit_product: got %h required 0000000180000000", {ph, pl});
    end
    step();
  endtask

  task automatic test_zero();
    int lat, na, ns, nc, la;
    logic [31:0] ph, pl;
    do_mul(32'h1234_5678, 32'd0, lat, ph, pl, na, ns, nc, la);
    n_cmp++;
    if (lat !== 65) begin n_err++; $display("FAIL zero_latency: got %0d required 65", lat); end
    n_cmp++;
    if ({ph, pl} !== 64'd0) begin n_err++; $display("FAIL zero_product: got %h required 0", {ph, pl}); end
    n_cmp++;
    if (na + ns !== 0) begin n_err++; $display("FAIL zero_alu_idle: got %0d active cycles required 0", na + ns); end
    step();
  endtask

  task automatic test_back_to_back();
    int done1 = -1, done2 = -1, acc2 = -1, early = 0;
    logic [63:0] p1 = '0, p2 = '0;
    start = 1'b1; mcand = 32'd6; mplier = 32'd7;
    for (int c = 1; c <= 300; c++) begin
      step();
      if (c == 10) begin mcand = 32'd11; mplier = 32'd13; end
      if (done) begin
        if (done1 < 0) begin done1 = c; p1 = {product_hi, product_lo}; end
        else begin done2 = c; p2 = {product_hi, product_lo}; break; end
      end
      if (ready && done1 < 0) early++;
      if (ready && done1 >= 0 && acc2 < 0) acc2 = c;
    end
    start = 1'b0;
    n_cmp++;
    if (done1 !== 68 || p1 !== 64'd42) begin
      n_err++; $display("FAIL b2b_first: got cycle=%0d prod=%h required 68 42", done1, p1);
    end
    n_cmp++;
    if (early !== 0 || acc2 !== 69) begin
      n_err++; $display("FAIL b2b_accept: got early_ready=%0d accept=%0d required 0 69", early, acc2);
    end
    n_cmp++;
    if (done2 !== 137 || p2 !== 64'd143) begin
      n_err++; $display("FAIL b2b_second: got cycle=%0d prod=%h required 137 143", done2, p2);
    end
    step();
  endtask

  task automatic test_reset_abort();
    int lat, na, ns, nc, la, seen_done = 0;
    logic [31:0] ph, pl;
    start = 1'b1; mcand = 32'd7; mplier = 32'd9;
    for (int c = 1; c <= 20; c++) begin
      step();
      start = 1'b0;
      if (done) seen_done++;
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (ready !== 1'b1 || {product_hi, product_lo} !== 64'd0 || alu_op !== OP_IDLE) begin
      n_err++; $display("FAIL abort_clear: got ready=%b prod=%h op=%h required 1 0 0",
                        ready, {product_hi, product_lo}, alu_op);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      if (done) seen_done++;
    end
    reset_n = 1'b1;
    step();
    if (done) seen_done++;
    n_cmp++;
    if (seen_done !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d pulses required 0", seen_done); end
    do_mul(32'd7, 32'd9, lat, ph, pl, na, ns, nc, la);
    n_cmp++;
    if (lat !== 67 || {ph, pl} !== 64'd63) begin
      n_err++; $display("FAIL abort_rerun: got lat=%0d prod=%h required 67 63", lat, {ph, pl});
    end
    step();
  endtask

  initial begin
    #1;
    test_reset();
    step();
    step();
    reset_n = 1'b1;
    step();
    test_small();
    test_max();
    test_high_bit();
    test_zero();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
